dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RISC-V core: the slave end of the Memory-stage load/store interface. It accepts byte/half/word loads and stores addressed by the M-stage ALU result. It inserts a configurable number of wait states, signalled as a pipeline stall request, and returns sign- or zero-extended read data to the Writeback register. It sits between the core's M stage and a local byte-addressable RAM array.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- WAIT_CYCLES, 2: stall cycles per access; 0..15.
---
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemReadM  in  1  load request from M stage.
- MemWriteM  in  1  store request from M stage.
- Funct3M  in  3  access size and signedness (RV32I load/store funct3).
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  extended load data; valid when MemBusyM=0 and a load is present.
- MemBusyM  out  1  stall request to hazard logic; holds the F, D, E and M stages.
- MisalignM  out  1  misaligned-access flag; tied 0 when the feature is compiled out.

## Operation
- A request is MemReadM|MemWriteM. When both are asserted, the access is a store and ReadDataM=0.
- Word index is ALUResultM[$clog2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS.
- Size decode by Funct3M:
  - 000 lb/sb: byte lane ALUResultM[1:0]; load sign-extended.
  - 001 lh/sh: half lane ALUResultM[1]; load sign-extended.
  - 010 lw/sw: full word.
  - 100 lbu: byte lane, zero-extended.
  - 101 lhu: half lane, zero-extended.
  - All other codes: load returns 0; store suppressed.
- Stores write only the addressed byte lanes; the other lanes are unchanged.
- FSM states:
  - IDLE: on a request with WAIT_CYCLES>0, MemBusyM=1 combinationally, counter loaded with WAIT_CYCLES-1, next state WAIT. With WAIT_CYCLES=0 the access completes in IDLE.
  - WAIT: MemBusyM=1; counter decrements each cycle; when counter=0, next state DONE.
  - DONE: MemBusyM=0; ReadDataM driven from the array; a store commits on the edge leaving DONE; next state IDLE.
- The M-stage inputs are held stable by the stall for the whole access.
- When no load is being completed, ReadDataM=0.

## Timing
- Reset values: state IDLE, counter 0, MemBusyM=0, ReadDataM=0, MisalignM=0. RAM contents are not reset.
- Load latency: MemBusyM is high for exactly WAIT_CYCLES cycles starting in the request cycle. Data is valid in the following cycle (DONE) and is captured by the W register at the end of that cycle.
- Store commit occurs at the end of the DONE cycle, or at the end of the request cycle when WAIT_CYCLES=0.
- Back-to-back accesses: a request present in the cycle after DONE starts a new access from IDLE. No idle bubble is required beyond DONE.
- Reset asserted mid-access: return to IDLE immediately; the pending store is not committed; MemBusyM drops asynchronously.
- The read path is combinational from the array and current address; there is no read-data register.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - A halfword access with ALUResultM[0]=1, or a word access with ALUResultM[1:0]≠0, raises MisalignM combinationally.
  - Such an access completes with no wait states, the store is suppressed, and ReadDataM=0.
- DMEM_MISALIGN_CHECK_EN undefined:
  - MisalignM=0.
  - Halfword accesses ignore ALUResultM[0]; word accesses ignore ALUResultM[1:0].

## Structure
- Package dmem_pkg holds:
  - Funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum dmem_state_t {IDLE, WAIT, DONE}.
  - A function computing the 4-bit byte-enable from size and address.
- Sub-module dmem_bytelane_ram: DEPTH_WORDS x 32 array with 4-bit byte-enable synchronous write and asynchronous read.
- The responder owns the FSM, counter, lane steering and extension logic.

## Test plan
- WAIT_CYCLES=2; sw 0xDEADBEEF @0x10, then lw @0x10 → MemBusyM high 2 cycles per access, then ReadDataM=0xDEADBEEF in DONE.
- Word 0x80FF7F01 @0x20: lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lh @0x22 → 0xFFFF80FF; lhu @0x20 → 0x00007F01.
- sb 0xAA @0x31 over word 0x11223344 @0x30 → lw @0x30 returns 0x1122AA44.
- Reset asserted during WAIT of sw 0x12345678 @0x40 (old 0) → MemBusyM=0 immediately; lw @0x40 returns 0.
- WAIT_CYCLES=0; lw @0x1000 with DEPTH_WORDS=1024 → MemBusyM never asserted; reads word @0x0 (wrap).
- With DMEM_MISALIGN_CHECK_EN: sw @0x42 → MisalignM=1, no stall, word @0x40 unchanged; without the macro the same store writes word @0x40.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the data-memory responder.
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_t;

  // Byte lanes touched by an access; zero for undefined size codes.
  // Halfwords select the lane pair with a[1] only, words ignore a entirely.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << a;
      F3_H, F3_HU: be = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Natural-alignment violation for halfword and word accesses.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = a[0];
      F3_W:        mis = (a != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-organised RAM with per-byte write enables and combinational read.
module dmem_bytelane_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write only the enabled byte lanes; other lanes keep their contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: wait-state FSM, lane steering and load extension.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag and squash misaligned
// halfword/word accesses; otherwise MisalignM is tied low and low address bits are ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MisalignM
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Busy cycles still owed after the request cycle
  localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        req, is_load, is_store, misalign;
  logic        busy, complete, ram_we;
  logic [3:0]  be;
  logic [31:0] wdata_lanes, rdata_word, rdata_shift, load_data;
  logic        unused_addr;

  assign req      = MemReadM | MemWriteM;
  assign is_store = MemWriteM;
  assign is_load  = MemReadM & ~MemWriteM;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = req & addr_misaligned(Funct3M, ALUResultM[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits beyond the array wrap away
  assign unused_addr = ^ALUResultM[31:AW+2];

  // State and wait counter; async reset abandons any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, busy request and completion strobe.
  // cnt counts remaining busy cycles so MemBusyM spans exactly WAIT_CYCLES cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !misalign) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            busy    = 1'b1;
            cnt_d   = WaitLoad;
            state_d = (WaitLoad == 4'd0) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        complete = req & ~misalign;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign be = byte_enable(Funct3M, ALUResultM[1:0]);

  // Replicate store data across lanes so the byte enables pick the right copy
  always_comb begin
    wdata_lanes = WriteDataM;
    case (Funct3M[1:0])
      2'b00:   wdata_lanes = {4{WriteDataM[7:0]}};
      2'b01:   wdata_lanes = {2{WriteDataM[15:0]}};
      default: wdata_lanes = WriteDataM;
    endcase
  end

  assign ram_we = complete & is_store & ~reset;

  dmem_bytelane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .be_i   (be),
    .addr_i (ALUResultM[AW+1:2]),
    .wdata_i(wdata_lanes),
    .rdata_o(rdata_word)
  );

  assign rdata_shift = rdata_word >> {ALUResultM[1:0], 3'b000};

  // Select the addressed lane and sign/zero extend
  always_comb begin
    load_data = 32'd0;
    case (Funct3M)
      F3_B:    load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      F3_BU:   load_data = {24'd0, rdata_shift[7:0]};
      F3_H:    load_data = ALUResultM[1] ? {{16{rdata_word[31]}}, rdata_word[31:16]}
                                         : {{16{rdata_word[15]}}, rdata_word[15:0]};
      F3_HU:   load_data = ALUResultM[1] ? {16'd0, rdata_word[31:16]}
                                         : {16'd0, rdata_word[15:0]};
      F3_W:    load_data = rdata_word;
      default: load_data = 32'd0;
    endcase
  end

  assign ReadDataM = (complete && is_load && !reset) ? load_data : 32'd0;
  assign MemBusyM  = busy & ~reset;
  assign MisalignM = misalign & ~reset;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  localparam int WC = 2;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  logic [31:0] rdata;
  logic        busy, mis;

  logic        rd0, wr0;
  logic [2:0]  f30;
  logic [31:0] addr0, wd0;
  logic [31:0] rdata0;
  logic        busy0, mis0;

  exp_t q_main[$];
  exp_t q_zero[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(WC)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .MemReadM  (rd),
    .MemWriteM (wr),
    .Funct3M   (f3),
    .ALUResultM(addr),
    .WriteDataM(wd),
    .ReadDataM (rdata),
    .MemBusyM  (busy),
    .MisalignM (mis)
  );

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .MemReadM  (rd0),
    .MemWriteM (wr0),
    .Funct3M   (f30),
    .ALUResultM(addr0),
    .WriteDataM(wd0),
    .ReadDataM (rdata0),
    .MemBusyM  (busy0),
    .MisalignM (mis0)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: a load completes whenever the main DUT shows a load with no stall
  always @(negedge clk) begin
    if (!reset && rd && !wr && !busy) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_completion", rdata, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q_main.pop_front();
        check(e.name, rdata, e.data);
      end
    end
  end

  // Monitor for the zero-wait DUT: every load completes in its request cycle
  always @(negedge clk) begin
    if (!reset && rd0 && !wr0) begin
      if (q_zero.size() == 0) begin
        check("zero_unexpected_completion", rdata0, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q_zero.pop_front();
        check(e.name, rdata0, e.data);
      end
    end
  end

  // One access on the main DUT; called just after a rising edge
  task automatic access(input string name, input logic r, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                        input int exp_busy, input logic exp_mis);
    int busy_n;
    exp_t e;
    if (r && !w) begin
      e.name = name;
      e.data = exp_rd;
      q_main.push_back(e);
    end
    rd = r; wr = w; f3 = fn; addr = a; wd = d;
    busy_n = 0;
    @(negedge clk);
    check({name, "_misalign"}, 32'(mis), 32'(exp_mis));
    while (busy && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    if (r && w) check({name, "_rdata_zero"}, rdata, 32'd0);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  // One access on the zero-wait DUT
  task automatic access0(input string name, input logic r, input logic w, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    exp_t e;
    if (r && !w) begin
      e.name = name;
      e.data = exp_rd;
      q_zero.push_back(e);
    end
    rd0 = r; wr0 = w; f30 = fn; addr0 = a; wd0 = d;
    @(negedge clk);
    check({name, "_busy"}, 32'(busy0), 32'd0);
    @(posedge clk);
    #1;
    rd0 = 1'b0; wr0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd = 1'b0; wr = 1'b0; f3 = 3'b010; addr = 32'd0; wd = 32'd0;
    rd0 = 1'b0; wr0 = 1'b0; f30 = 3'b010; addr0 = 32'd0; wd0 = 32'd0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_misalign", 32'(mis), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word store then load
    access("sw_10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, WC, 1'b0);
    access("lw_10", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, WC, 1'b0);

    // Sign/zero extension across lanes
    access("sw_20",  1'b0, 1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'd0, WC, 1'b0);
    access("lb_23",  1'b1, 1'b0, 3'b000, 32'h23, 32'd0, 32'hFFFFFF80, WC, 1'b0);
    access("lbu_23", 1'b1, 1'b0, 3'b100, 32'h23, 32'd0, 32'h00000080, WC, 1'b0);
    access("lh_22",  1'b1, 1'b0, 3'b001, 32'h22, 32'd0, 32'hFFFF80FF, WC, 1'b0);
    access("lhu_20", 1'b1, 1'b0, 3'b101, 32'h20, 32'd0, 32'h00007F01, WC, 1'b0);

    // Partial stores leave the other lanes alone
    access("sw_30", 1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, 32'd0, WC, 1'b0);
    access("sb_31", 1'b0, 1'b1, 3'b000, 32'h31, 32'hFFFFFFAA, 32'd0, WC, 1'b0);
    access("lw_30", 1'b1, 1'b0, 3'b010, 32'h30, 32'd0, 32'h1122AA44, WC, 1'b0);
    access("sw_34", 1'b0, 1'b1, 3'b010, 32'h34, 32'h00000000, 32'd0, WC, 1'b0);
    access("sh_36", 1'b0, 1'b1, 3'b001, 32'h36, 32'h1234BEEF, 32'd0, WC, 1'b0);
    access("lw_34", 1'b1, 1'b0, 3'b010, 32'h34, 32'd0, 32'hBEEF0000, WC, 1'b0);

    // Read+write together behaves as a store
    access("rw_50", 1'b1, 1'b1, 3'b010, 32'h50, 32'h0BADF00D, 32'd0, WC, 1'b0);
    access("lw_50", 1'b1, 1'b0, 3'b010, 32'h50, 32'd0, 32'h0BADF00D, WC, 1'b0);

    // Undefined funct3: load returns 0, store suppressed
    access("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, WC, 1'b0);
    access("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 32'd0, WC, 1'b0);
    access("lw_10_kept", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, WC, 1'b0);

    // Reset during the WAIT state of a store
    access("sw_40_clear", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'd0, WC, 1'b0);
    wr = 1'b1; f3 = 3'b010; addr = 32'h40; wd = 32'h12345678;
    @(negedge clk);
    check("rst_req_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_busy_held", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    wr = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    access("lw_40_after_rst", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'd0, WC, 1'b0);

    // Misaligned word store
    access("sw_40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h55667788, 32'd0, WC, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    access("sw_42_mis", 1'b0, 1'b1, 3'b010, 32'h42, 32'hA5A5A5A5, 32'd0, 0, 1'b1);
    access("lw_40_mis", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'h55667788, WC, 1'b0);
`else
    access("sw_42_mis", 1'b0, 1'b1, 3'b010, 32'h42, 32'hA5A5A5A5, 32'd0, WC, 1'b0);
    access("lw_40_mis", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'hA5A5A5A5, WC, 1'b0);
`endif

    // Zero-wait instance: no stall, address wrap modulo DEPTH_WORDS
    access0("z_sw_0",    1'b0, 1'b1, 3'b010, 32'h0,    32'hCAFEF00D, 32'd0);
    access0("z_lw_1000", 1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 32'hCAFEF00D);
    access0("z_sb_1003", 1'b0, 1'b1, 3'b000, 32'h1003, 32'h00000011, 32'd0);
    access0("z_lw_0",    1'b1, 1'b0, 3'b010, 32'h0,    32'd0, 32'h11FEF00D);
    access0("z_lhu_2",   1'b1, 1'b0, 3'b101, 32'h2,    32'd0, 32'h000011FE);

    repeat (3) @(posedge clk);
    check("main_queue_drained", 32'(q_main.size()), 32'd0);
    check("zero_queue_drained", 32'(q_zero.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
